// File: rtl/memory_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : memory_controller
// Description : Owner of the 8-bit RAM/IO bus. Arbitrates between instruction
//               fetch and the load/store buffer, splits each request into
//               byte-serial accesses and assembles little-endian results.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_controller #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_signal,
    input  logic                  io_buffer_full,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    input  logic                  if_signal,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_data,
    output logic                  if_done,
    input  logic                  lsb_signal,
    input  logic                  lsb_wr,
    input  logic                  lsb_signed,
    input  logic [1:0]            lsb_len,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [31:0]           lsb_din,
    output logic [31:0]           lsb_dout,
    output logic                  lsb_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;       // READ: edges since accept; WRITE: byte index on bus
    logic [2:0]  r_n;         // number of bytes in the transfer (1, 2 or 4)
    logic        r_is_lsb;    // current client is the load/store buffer
    logic        r_last_lsb;  // last grant went to the load/store buffer
    logic        r_signed;
    logic        r_io;        // store targets the memory-mapped IO window
    logic [31:0] r_wdata;
    logic [23:0] r_buf;       // bytes 0..2 captured so far
    logic        r_ram_wr;

    logic        w_if_req;
    logic        w_lsb_req;
    logic        w_pick_lsb;
    logic [2:0]  w_lsb_n;
    logic        w_io_new;
    logic        w_stall;
    logic        w_ext;
    logic [31:0] w_result;

    // A flush blocks new loads/fetches but a store may still be accepted
    assign w_if_req   = if_signal & ~clear_signal;
    assign w_lsb_req  = lsb_signal & (lsb_wr | ~clear_signal);
    assign w_pick_lsb = w_lsb_req & (~w_if_req | ~r_last_lsb);
    assign w_lsb_n    = (lsb_len == 2'b00) ? 3'd1 : (lsb_len == 2'b01) ? 3'd2 : 3'd4;
    assign w_io_new   = (lsb_addr[17:16] == IO_ADDR_HI);
    assign w_stall    = r_io & io_buffer_full;
    assign w_ext      = r_signed & ram_din[7];

    // The write strobe is suppressed while the pipeline is paused
    assign ram_wr = r_ram_wr & rdy_in;

    function automatic logic [7:0] f_byte(input logic [31:0] d, input logic [1:0] k);
        case (k)
            2'd0:    f_byte = d[7:0];
            2'd1:    f_byte = d[15:8];
            2'd2:    f_byte = d[23:16];
            default: f_byte = d[31:24];
        endcase
    endfunction

    // Final assembly: the last byte arrives on ram_din at the completing edge
    always_comb begin
        w_result = 32'h0;
        case (r_n)
            3'd1:    w_result = {{24{w_ext}}, ram_din};
            3'd2:    w_result = {{16{w_ext}}, ram_din, r_buf[7:0]};
            default: w_result = {ram_din, r_buf[23:0]};
        endcase
    end

    // Controller state machine with registered bus and client outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_n        <= 3'd0;
            r_is_lsb   <= 1'b0;
            r_last_lsb <= 1'b0;
            r_signed   <= 1'b0;
            r_io       <= 1'b0;
            r_wdata    <= 32'h0;
            r_buf      <= 24'h0;
            r_ram_wr   <= 1'b0;
            ram_dout   <= 8'h0;
            ram_addr   <= '0;
            if_data    <= 32'h0;
            if_done    <= 1'b0;
            lsb_dout   <= 32'h0;
            lsb_done   <= 1'b0;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (w_if_req | w_lsb_req) begin
                        r_is_lsb   <= w_pick_lsb;
                        r_last_lsb <= w_pick_lsb;
                        r_cnt      <= 3'd0;
                        if (w_pick_lsb) begin
                            r_signed <= lsb_signed;
                            r_n      <= w_lsb_n;
                            r_wdata  <= lsb_din;
                            r_io     <= w_io_new;
                            ram_addr <= lsb_addr;
                            if (lsb_wr) begin
                                ram_dout <= lsb_din[7:0];
                                r_ram_wr <= ~(w_io_new & io_buffer_full);
                                r_state  <= S_WRITE;
                            end else begin
                                r_state  <= S_READ;
                            end
                        end else begin
                            r_signed <= 1'b0;
                            r_n      <= 3'd4;
                            r_io     <= 1'b0;
                            ram_addr <= if_addr;
                            r_state  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (clear_signal) begin
                        r_state  <= S_IDLE;
                        if_done  <= 1'b0;
                        lsb_done <= 1'b0;
                    end else begin
                        if (r_cnt < r_n - 3'd1)
                            ram_addr <= ram_addr + ADDR_WIDTH'(1);
                        case (r_cnt)
                            3'd1:    r_buf[7:0]   <= ram_din;
                            3'd2:    r_buf[15:8]  <= ram_din;
                            3'd3:    r_buf[23:16] <= ram_din;
                            default: ;
                        endcase
                        if (r_cnt == r_n) begin
                            if (r_is_lsb) begin
                                lsb_dout <= w_result;
                                lsb_done <= 1'b1;
                            end else begin
                                if_data  <= w_result;
                                if_done  <= 1'b1;
                            end
                            r_state <= S_DONE;
                        end
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_WRITE: begin
                    // A byte counts as written only after a cycle with the strobe high
                    if (r_ram_wr) begin
                        if (r_cnt == r_n - 3'd1) begin
                            r_ram_wr <= 1'b0;
                            lsb_done <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt    <= r_cnt + 3'd1;
                            ram_addr <= ram_addr + ADDR_WIDTH'(1);
                            ram_dout <= f_byte(r_wdata, r_cnt[1:0] + 2'd1);
                            r_ram_wr <= ~w_stall;
                        end
                    end else begin
                        r_ram_wr <= ~w_stall;
                    end
                end
                default: begin
                    // Requests are still held on this edge, so none are taken here
                    if_done  <= 1'b0;
                    lsb_done <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_memory_controller
// Description : Directed bench for memory_controller with a byte RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_controller;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear_signal = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic        if_signal = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_data;
    logic        if_done;
    logic        lsb_signal = 1'b0;
    logic        lsb_wr = 1'b0;
    logic        lsb_signed = 1'b0;
    logic [1:0]  lsb_len = 2'b00;
    logic [31:0] lsb_addr = 32'h0;
    logic [31:0] lsb_din = 32'h0;
    logic [31:0] lsb_dout;
    logic        lsb_done;

    int total = 0;
    int bad   = 0;

    memory_controller #(.ADDR_WIDTH(32), .IO_ADDR_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .clear_signal(clear_signal), .io_buffer_full(io_buffer_full),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr),
        .if_signal(if_signal), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .lsb_signal(lsb_signal), .lsb_wr(lsb_wr), .lsb_signed(lsb_signed),
        .lsb_len(lsb_len), .lsb_addr(lsb_addr), .lsb_din(lsb_din),
        .lsb_dout(lsb_dout), .lsb_done(lsb_done)
    );

    always #5 clk_in = ~clk_in;

    // Byte RAM: read data valid one cycle after the address
    logic [7:0] mem [0:262143];
    logic       preloaded = 1'b0;
    int         io_writes = 0;
    always @(posedge clk_in) begin
        if (!preloaded) begin
            mem[18'h00100] <= 8'h13;
            mem[18'h00101] <= 8'h05;
            mem[18'h00102] <= 8'h00;
            mem[18'h00103] <= 8'h00;
            mem[18'h00200] <= 8'h80;
            mem[18'h00201] <= 8'h00;
            mem[18'h00202] <= 8'hFF;
            mem[18'h00203] <= 8'h80;
            preloaded      <= 1'b1;
        end
        if (ram_wr) begin
            mem[ram_addr[17:0]] <= ram_dout;
            if (ram_addr == 32'h0003_0000)
                io_writes <= io_writes + 1;
        end
        ram_din <= mem[ram_addr[17:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] len,
                           input logic sgn, input logic [31:0] exp, input string tag);
        int n;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        lsb_addr = addr; lsb_len = len; lsb_signed = sgn; lsb_wr = 1'b0; lsb_signal = 1'b1;
        tick();                       // E0
        repeat (n) tick();            // E0+n
        check({tag, "_early"}, 32'(lsb_done), 32'h0);
        tick();                       // E0+n+1
        check({tag, "_done"}, 32'(lsb_done), 32'h1);
        check({tag, "_data"}, lsb_dout, exp);
        lsb_signal = 1'b0;
        tick();
        check({tag, "_drop"}, 32'(lsb_done), 32'h0);
    endtask

    initial begin
        int          ev_i[$];
        logic        ev_c[$];
        int          exp_i[4] = '{3, 10, 14, 21};
        logic        exp_c[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  eb[4]    = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int          acc;

        // ---------------- reset state ----------------
        #1;
        check("rst_ctrl", {29'h0, ram_wr, if_done, lsb_done}, 32'h0);
        check("rst_addr", ram_addr, 32'h0);
        check("rst_dout", {24'h0, ram_dout}, 32'h0);
        check("rst_ifdata", if_data, 32'h0);
        check("rst_lsbdout", lsb_dout, 32'h0);
        repeat (3) tick();
        rst_in = 1'b1;
        tick();

        // ---------------- arbitration ----------------
        if_addr = 32'h100; lsb_addr = 32'h200; lsb_len = 2'b00; lsb_wr = 1'b0; lsb_signed = 1'b0;
        if_signal = 1'b1; lsb_signal = 1'b1;
        acc = 0;
        for (int i = 1; i <= 22; i++) begin
            tick();
            acc += 32'(ram_wr);
            if (lsb_done) begin ev_i.push_back(i); ev_c.push_back(1'b1); end
            if (if_done)  begin ev_i.push_back(i); ev_c.push_back(1'b0); end
        end
        if_signal = 1'b0; lsb_signal = 1'b0;
        check("arb_events", 32'(ev_i.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("arb_cycle", (k < ev_i.size()) ? 32'(ev_i[k]) : 32'hFFFF_FFFF, 32'(exp_i[k]));
            check("arb_client", (k < ev_c.size()) ? 32'(ev_c[k]) : 32'hFFFF_FFFF, 32'(exp_c[k]));
        end
        check("arb_no_wr", 32'(acc), 32'h0);
        check("arb_ifdata", if_data, 32'h0000_0513);
        check("arb_lsbdout", lsb_dout, 32'h0000_0080);
        repeat (2) tick();

        // ---------------- fetch ----------------
        if_addr = 32'h100; if_signal = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fetch_addr", ram_addr, 32'h100 + 32'(k));
        end
        tick();
        check("fetch_early", 32'(if_done), 32'h0);
        tick();
        check("fetch_done", 32'(if_done), 32'h1);
        check("fetch_data", if_data, 32'h0000_0513);
        if_signal = 1'b0;
        tick();
        check("fetch_pulse", 32'(if_done), 32'h0);

        // ---------------- loads ----------------
        do_load(32'h100, 2'b11, 1'b0, 32'h0000_0513, "ld_word");
        do_load(32'h200, 2'b00, 1'b1, 32'hFFFF_FF80, "ld_sb");
        do_load(32'h202, 2'b01, 1'b0, 32'h0000_80FF, "ld_uh");
        do_load(32'h202, 2'b01, 1'b1, 32'hFFFF_80FF, "ld_sh");

        // ---------------- word store ----------------
        lsb_addr = 32'h1000; lsb_din = 32'hDEAD_BEEF; lsb_len = 2'b11; lsb_wr = 1'b1;
        lsb_signal = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("st_wr", 32'(ram_wr), 32'h1);
            check("st_addr", ram_addr, 32'h1000 + 32'(k));
            check("st_byte", {24'h0, ram_dout}, {24'h0, eb[k]});
        end
        tick();
        check("st_done", {30'h0, lsb_done, ram_wr}, 32'h2);
        lsb_signal = 1'b0;
        tick();
        check("st_after", {30'h0, lsb_done, ram_wr}, 32'h0);
        check("st_mem", {mem[18'h1003], mem[18'h1002], mem[18'h1001], mem[18'h1000]}, 32'hDEAD_BEEF);

        // ---------------- clear during load ----------------
        lsb_addr = 32'h200; lsb_len = 2'b11; lsb_wr = 1'b0; lsb_signed = 1'b0; lsb_signal = 1'b1;
        tick(); tick();
        clear_signal = 1'b1; lsb_signal = 1'b0;
        tick();
        clear_signal = 1'b0;
        check("clr_ld_done", 32'(lsb_done), 32'h0);
        if_addr = 32'h100; if_signal = 1'b1;
        tick();
        check("clr_ld_idle", ram_addr, 32'h100);
        acc = 0;
        repeat (4) begin tick(); acc += 32'(lsb_done); end
        tick();
        acc += 32'(lsb_done);
        check("clr_ld_fetch", 32'(if_done), 32'h1);
        check("clr_ld_nodone", 32'(acc), 32'h0);
        check("clr_ld_noresult", lsb_dout, 32'hFFFF_80FF);
        if_signal = 1'b0;
        tick();

        // ---------------- clear during store ----------------
        lsb_addr = 32'h2000; lsb_din = 32'h1122_3344; lsb_len = 2'b11; lsb_wr = 1'b1;
        lsb_signal = 1'b1;
        tick();
        clear_signal = 1'b1;
        tick();
        clear_signal = 1'b0;
        tick(); tick(); tick();
        check("clr_st_done", 32'(lsb_done), 32'h1);
        lsb_signal = 1'b0;
        tick();
        check("clr_st_mem", {mem[18'h2003], mem[18'h2002], mem[18'h2001], mem[18'h2000]}, 32'h1122_3344);

        // ---------------- IO stall ----------------
        lsb_addr = 32'h0003_0000; lsb_din = 32'h41; lsb_len = 2'b00; lsb_wr = 1'b1;
        io_buffer_full = 1'b1; lsb_signal = 1'b1;
        acc = 0;
        repeat (3) begin tick(); acc += 32'(ram_wr); end
        check("io_stall", 32'(acc), 32'h0);
        io_buffer_full = 1'b0;
        tick();
        check("io_write", {23'h0, ram_wr, ram_dout}, 32'h141);
        tick();
        check("io_done", {30'h0, lsb_done, ram_wr}, 32'h2);
        lsb_signal = 1'b0;
        tick();
        check("io_count", 32'(io_writes), 32'h1);
        check("io_mem", {24'h0, mem[18'h30000]}, 32'h41);

        // ---------------- async reset mid-store ----------------
        lsb_addr = 32'h3000; lsb_din = 32'hCAFE_F00D; lsb_len = 2'b11; lsb_wr = 1'b1;
        lsb_signal = 1'b1;
        tick(); tick();
        check("ar_pre_wr", 32'(ram_wr), 32'h1);
        #2 rst_in = 1'b0;
        #1;
        check("ar_ctrl", {29'h0, ram_wr, if_done, lsb_done}, 32'h0);
        check("ar_addr", ram_addr, 32'h0);
        check("ar_dout", {24'h0, ram_dout}, 32'h0);
        check("ar_data", if_data | lsb_dout, 32'h0);
        lsb_signal = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Single owner of the 8-bit unified RAM/IO bus.
- Serves two clients: the instruction fetch unit (always 4-byte reads) and the load/store buffer (1/2/4-byte loads and stores).
- Splits each request into byte-serial RAM accesses, assembles little-endian results, and returns a one-cycle done pulse.
- Sits directly downstream of the load/store buffer; its lsb_* port mirrors that block's mem_* port.

Parameters:
- ADDR_WIDTH, 32, width of client and RAM addresses
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks memory-mapped IO

Ports:
- clk_in  input  1  system clock, rising edge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  pause when low
- clear_signal  input  1  misprediction flush
- io_buffer_full  input  1  UART output buffer full
- ram_din  input  8  byte read from RAM, valid one cycle after address
- ram_dout  output  8  byte to write
- ram_addr  output  ADDR_WIDTH  byte address
- ram_wr  output  1  1 = write this cycle
- if_signal  input  1  fetch request, held until if_done
- if_addr  input  ADDR_WIDTH  fetch address
- if_data  output  32  fetched word
- if_done  output  1  one-cycle completion pulse
- lsb_signal  input  1  load/store request, held until lsb_done
- lsb_wr  input  1  1 = store
- lsb_signed  input  1  1 = sign-extend load
- lsb_len  input  2  00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes
- lsb_addr  input  ADDR_WIDTH  effective address
- lsb_din  input  32  store data
- lsb_dout  output  32  load result
- lsb_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_in = 0, asynchronous, any time including mid-operation):
  - All outputs go to 0; state goes to IDLE; byte counter to 0; round-robin pointer favours LSB.
- rdy_in low: no register changes; ram_wr output forced to 0.
- Byte count n = lsb_len + 1 (len 10 is treated as 11); fetch n = 4. Byte k uses address base + k.
- States: IDLE, READ, WRITE, DONE.
- IDLE, request accepted on edge E0:
  - Only one requester: serve it.
  - Both requesting: serve the client not served last.
  - Latch client, wr, signed, n, base, data; ram_addr <= base; cnt <= 0.
  - Load or fetch goes to READ; store goes to WRITE.
- READ:
  - ram_addr advances by 1 each edge until byte n-1 has been presented.
  - Byte k is captured from ram_din at edge E0+k+2.
  - At edge E0+n+1 the result is assembled:
    - little-endian, byte 0 in bits [7:0];
    - bits above 8n are zero, or replicate the top loaded bit when signed = 1 and n < 4.
  - At that edge the result goes to lsb_dout or if_data, the matching done goes to 1, and state goes to DONE.
  - Fetch: if_done at E0+5.
- WRITE:
  - Byte k is presented on edge E0+k with ram_wr = 1, ram_dout = data[8k+7:8k], ram_addr = base + k.
  - IO stall: if base[17:16] == IO_ADDR_HI and io_buffer_full = 1, ram_wr <= 0 and the byte is held until io_buffer_full = 0.
  - After the last byte: ram_wr <= 0, lsb_done <= 1, state goes to DONE. Unstalled store: done at E0+n.
- DONE:
  - Lasts exactly one cycle.
  - Done pulse drops to 0; requests are ignored, because the client still holds its signal at this edge; state goes to IDLE.
  - Back-to-back requests are therefore separated by at least one idle cycle.
- clear_signal = 1:
  - Aborts fetch and load in progress or in DONE: state goes to IDLE, if_done and lsb_done go to 0, no result is written.
  - A store in progress completes and still pulses lsb_done.
  - In IDLE with clear high, no new load or fetch is accepted that cycle; a store request is accepted.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- ram_wr is never 1 outside WRITE.

Test Plan:
- Fetch at 0x100, RAM bytes 13 05 00 00 -> ram_addr 0x100..0x103 on consecutive cycles; if_data = 0x00000513; if_done high for exactly 1 cycle at E0+5.
- Loads:
  - Signed byte at 0x200 (=0x80) -> lsb_dout = 0xFFFFFF80.
  - Unsigned halfword at 0x202 (bytes FF 80) -> 0x000080FF.
  - Signed halfword same bytes -> 0xFFFF80FF.
- Store word 0xDEADBEEF to 0x1000 -> ram writes EF, BE, AD, DE at 0x1000..0x1003 on 4 consecutive cycles; lsb_done at E0+4; ram_wr = 0 afterwards.
- Arbitration: if_signal and lsb_signal both held continuously -> grants alternate LSB, IF, LSB, IF; one DONE cycle between each; no request re-accepted on its own done edge.
- clear_signal:
  - Pulsed 2 cycles into a 4-byte load -> no lsb_done, state IDLE next cycle.
  - Pulsed 1 cycle into a word store -> all 4 bytes written, lsb_done asserted.
- Reset and IO stall:
  - Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr stays 0 for 3 cycles, then one write of 0x41.
  - rst_in pulled low mid-store -> ram_wr drops to 0 immediately (asynchronously), outputs all 0.
